// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation engine.
// Holds the FSM state encoding and a latency helper.
package rsa_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_EXP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_SQUARE,
        S_MULT,
        S_FIN
    } state_t;

    // Cycles from start acceptance to the done pulse.
    function automatic int modexp_latency(
        input int w,
        input int e_bits,
        input int ones,
        input bit bad_mod
    );
        if (bad_mod) return 2;
        return 2 + (w + 1) * (1 + e_bits + ones);
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Interleaved serial modular multiplier: p = a*b mod n, MSB of b first.
// One iteration per cycle; rdy pulses W cycles after go.
module modmul_serial
    import rsa_pkg::*;
#(
    parameter int W = DEF_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         rdy,
    output logic [W-1:0] p
);

    localparam int RW = W + 2;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_n;
    logic [RW-1:0] r_r;
    logic [CW-1:0] r_cnt;
    logic          r_act;

    logic [RW-1:0] w_n;
    logic [RW-1:0] w_dbl;
    logic [RW-1:0] w_s1;
    logic [RW-1:0] w_s2;
    logic [RW-1:0] w_s3;

    // r < n keeps every intermediate below 2n, so W+2 bits never overflow.
    always_comb begin
        w_n   = {2'b00, r_n};
        w_dbl = {r_r[RW-2:0], 1'b0};
        w_s1  = (w_dbl >= w_n) ? w_dbl - w_n : w_dbl;
        w_s2  = r_b[W-1] ? w_s1 + {2'b00, r_a} : w_s1;
        w_s3  = (w_s2 >= w_n) ? w_s2 - w_n : w_s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_n   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                r_a   <= a;
                r_b   <= b;
                r_n   <= n;
                r_r   <= '0;
                r_cnt <= CW'(W);
                r_act <= 1'b1;
            end else if (r_act) begin
                r_r   <= w_s3;
                r_b   <= {r_b[W-2:0], 1'b0};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_act <= 1'b0;
                    rdy   <= 1'b1;
                end
            end
        end
    end

    assign p = r_r[W-1:0];

endmodule

// File: rtl/modexp_engine.sv
// Left-to-right square-and-multiply modexp over modmul_serial.
// MODEXP_SKIP_LZ_EN: start at the highest set exponent bit.
module modexp_engine
    import rsa_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int EXP_W = DEF_EXP_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     base,
    input  logic [W-1:0]     modulus,
    input  logic [EXP_W-1:0] exponent,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     result
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t           r_state;
    logic [W-1:0]     r_base;
    logic [W-1:0]     r_mod;
    logic [EXP_W-1:0] r_exp;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_bred;
    logic [IW-1:0]    r_idx;
    logic             r_nz;

    logic             w_go;
    logic             w_rdy;
    logic             w_small;
    logic             w_nz;
    logic [IW-1:0]    w_top;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_p;

    assign w_small = (r_mod < W'(2));

`ifdef MODEXP_SKIP_LZ_EN
    always_comb begin
        w_top = '0;
        for (int i = 0; i < EXP_W; i++)
            if (r_exp[i]) w_top = IW'(i);
    end
    assign w_nz = |r_exp;
`else
    assign w_top = IW'(EXP_W - 1);
    assign w_nz  = 1'b1;
`endif

    // Next multiply launches on the same edge the previous product lands.
    always_comb begin
        w_go = 1'b0;
        w_a  = w_p;
        w_b  = w_p;
        unique case (r_state)
            S_LOAD: if (!w_small) begin
                w_go = 1'b1;
                w_a  = W'(1);
                w_b  = r_base;
            end
            S_REDUCE: if (w_rdy && r_nz) begin
                w_go = 1'b1;
                w_a  = r_acc;
                w_b  = r_acc;
            end
            S_SQUARE: if (w_rdy) begin
                if (r_exp[r_idx]) begin
                    w_go = 1'b1;
                    w_b  = r_bred;
                end else if (r_idx != '0) begin
                    w_go = 1'b1;
                end
            end
            S_MULT: if (w_rdy && r_idx != '0) w_go = 1'b1;
            default: ;
        endcase
    end

    modmul_serial #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (w_go),
        .a     (w_a),
        .b     (w_b),
        .n     (r_mod),
        .rdy   (w_rdy),
        .p     (w_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_mod   <= '0;
            r_exp   <= '0;
            r_acc   <= '0;
            r_bred  <= '0;
            r_idx   <= '0;
            r_nz    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_base  <= base;
                        r_mod   <= modulus;
                        r_exp   <= exponent;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_small) begin
                        r_acc   <= '0;
                        r_state <= S_FIN;
                    end else begin
                        r_acc   <= W'(1);
                        r_idx   <= w_top;
                        r_nz    <= w_nz;
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: if (w_rdy) begin
                    r_bred  <= w_p;
                    r_state <= r_nz ? S_SQUARE : S_FIN;
                end
                S_SQUARE: if (w_rdy) begin
                    r_acc <= w_p;
                    if (r_exp[r_idx]) begin
                        r_state <= S_MULT;
                    end else if (r_idx == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                S_MULT: if (w_rdy) begin
                    r_acc <= w_p;
                    if (r_idx == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx   <= r_idx - IW'(1);
                        r_state <= S_SQUARE;
                    end
                end
                S_FIN: begin
                    result  <= r_acc;
                    err     <= w_small;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_engine.sv
// Scoreboard bench for modexp_engine against an arithmetic reference.
// Directed test-plan cases, random operands, busy-start and mid-run reset.
module tb_modexp_engine;
    import rsa_pkg::*;

    localparam int W  = 8;
    localparam int EW = 8;
    localparam int W9 = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0;
    logic [W-1:0]  modulus = '0;
    logic [EW-1:0] exponent = '0;
    logic          busy, done, err;
    logic [W-1:0]  result;

    logic          start9 = 1'b0;
    logic [W9-1:0] base9 = '0;
    logic [W9-1:0] mod9 = '0;
    logic [EW-1:0] exp9 = '0;
    logic          busy9, done9, err9;
    logic [W9-1:0] result9;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int res;
        bit er;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    modexp_engine #(.W(W), .EXP_W(EW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .modulus  (modulus),
        .exponent (exponent),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    modexp_engine #(.W(W9), .EXP_W(EW)) dut9 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start9),
        .base     (base9),
        .modulus  (mod9),
        .exponent (exp9),
        .busy     (busy9),
        .done     (done9),
        .err      (err9),
        .result   (result9)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic int ref_modexp(int b, int e, int m);
        longint r;
        if (m < 2) return 0;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return int'(r % m);
    endfunction

    function automatic int exp_lat(int w, int e, int m);
        int eb;
        if (m < 2) return 2;
`ifdef MODEXP_SKIP_LZ_EN
        eb = 0;
        for (int i = 0; i < EW; i++) if (e[i]) eb = i + 1;
`else
        eb = EW;
`endif
        return 2 + (w + 1) * (1 + eb + $countones(e));
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                m_e = q.pop_front();
                check("result", result, m_e.res);
                check("err", err, m_e.er);
                check("done_cycle", cyc, m_e.at);
                check("busy_at_done", busy, 1);
            end
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 600; t++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 600; t++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        check("done_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic issue(input int b, input int m, input int e);
        exp_t x;
        wait_idle();
        base = W'(b);
        modulus = W'(m);
        exponent = EW'(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x.res = ref_modexp(b, e, m);
        x.er = (m < 2);
        x.at = cyc + exp_lat(W, e, m);
        q.push_back(x);
        check("busy_after_start", busy, 1);
        base = W'($urandom);
        modulus = W'($urandom);
        exponent = EW'($urandom);
    endtask

    initial begin
        int k;
        bit got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(55, 21, 15);
        issue(4, 253, 13);
        issue(254, 255, 2);
        issue(77, 100, 0);
        issue(200, 1, 9);
        issue(0, 97, 5);
        issue(123, 0, 3);
        drain();

        // a second start while busy must be dropped
        issue(55, 21, 15);
        repeat (5) @(negedge clk);
        base = 8'd1;
        modulus = 8'd200;
        exponent = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        for (int i = 0; i < 16; i++)
            issue($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255));
        drain();

        wait_idle();
        base9 = 9'd300;
        mod9 = 9'd21;
        exp9 = 8'd1;
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        k = cyc;
        base9 = W9'($urandom);
        got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (done9) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("w9_done_seen", got, 1);
        check("w9_result", result9, ref_modexp(300, 1, 21));
        check("w9_err", err9, 0);
        check("w9_cycle", cyc, k + exp_lat(W9, 1, 21));

        issue(55, 21, 15);
        drain();
        wait_idle();
        base = 8'd55;
        modulus = 8'd21;
        exponent = 8'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_result", result, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_still_idle", busy, 0);

        issue(55, 21, 15);
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modexp_engine.md
Name: modexp_engine

Overview:
- Parametrised modular-exponentiation core: result = base^exponent mod modulus, left-to-right square-and-multiply.
- Successor to the fixed 6-bit multiply/lookup-table datapath: arbitrary widths, no RAM table, explicit start/busy/done handshake, asynchronous reset.
- Uses an interleaved serial modular multiplier.
- Sits between the operand-loading logic and the result register/display logic of the RSA top.

Parameters:
- W, 8: width of base, modulus and result.
- EXP_W, 8: width of exponent.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- base  in  W  message/ciphertext operand; captured on accepted start; any value, including base >= modulus.
- modulus  in  W  N; captured on accepted start.
- exponent  in  EXP_W  key (e or d); captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive.
- done  out  1  one-cycle pulse when result/err are valid.
- err  out  1  set with done when the captured modulus < 2.
- result  out  W  final value; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, err and result = 0; multiplier cleared.
- States: IDLE, LOAD, REDUCE, SQUARE, MULT, FIN.
- IDLE, start=1 → capture operands → LOAD. start while busy is ignored; no queueing.
- LOAD:
  - If modulus < 2 → FIN with err=1 and result=0.
  - Otherwise acc=1, bit index=EXP_W-1 → REDUCE.
- REDUCE: b_red = modmul(1, base), i.e. base mod modulus; handles base >= modulus.
- Per exponent bit, MSB first:
  - SQUARE: acc = modmul(acc, acc).
  - If bit=1 → MULT: acc = modmul(acc, b_red).
  - Decrement index; after bit 0 → FIN.
- FIN: result=acc, done=1 for one cycle → IDLE; busy drops the following cycle.
- modmul(a,b) is interleaved, MSB of b first, W iterations, internal width W+2:
  - r = 2r; if r >= n, r -= n.
  - If b[i], r += a; if r >= n, r -= n.
  - Requires a < n; b unrestricted. Output is always < n.
- Each modmul occupies exactly W+1 engine cycles: W iterations plus 1 handoff.
- Latency: start accepted at edge k → done high in cycle k+L.
  - L = 2 + (W+1)·(1 + E + popcount(exponent)), with E = EXP_W.
  - Error path: L = 2.
- exponent=0 → result=1 (modulus ≥ 2).
- base=0 → result=0 when exponent ≠ 0.
- Operand inputs may change freely after the start cycle without affecting the operation.
- Reset asserted mid-operation aborts it; no done pulse; start after rst_n release behaves as from power-up.

Optional Feature:
- Macro MODEXP_SKIP_LZ_EN.
- Defined:
  - LOAD loads the bit index with the position of the highest set exponent bit.
  - E = that position + 1, or 0 for exponent=0.
  - Leading zero bits cost no cycles.
- Undefined: all EXP_W bits are processed; latency depends only on popcount.
- Result values are identical either way.

Decomposition:
- Package rsa_pkg:
  - State encoding constants.
  - Default W/EXP_W.
  - A latency function for benches.
- Sub-module modmul_serial (parameter W):
  - Ports clk, rst_n, go, a, b, n, rdy, p.
  - rdy pulses with p valid W cycles after go.
  - Engine holds the FSM, operand registers and bit index.

Test Plan:
- W=8, EXP_W=8, base=55, modulus=21, exponent=15:
  - result=13, err=0.
  - done at L=119 without MODEXP_SKIP_LZ_EN; at L=83 with it.
- base=4, modulus=253, exponent=13 → result=108.
- base=254, modulus=255, exponent=2 → result=1.
- base=300 truncation check with W=9, modulus=21, exponent=1 → result=6, proving the REDUCE path.
- exponent=0, base=77, modulus=100 → result=1.
- modulus=1 → err=1, result=0, done at L=2.
- Second start pulsed while busy is ignored.
- rst_n pulsed low mid-SQUARE → outputs 0 immediately, no done.
- A fresh start afterwards (55, 21, 15) returns 13 at nominal latency.
